// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store over valid/ready,
// fixed access latency, word-addressed array cleared on reset.
// Optional byte-enable stores when DMEM_BYTE_EN_EN is defined.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        enter_resp;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_err;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0] wr_mask;
    logic [31:0] wr_word;

    logic [31:0] mem [DEPTH_WORDS];

`ifdef DMEM_BYTE_EN_EN
    logic [3:0]  lat_be;
    logic [3:0]  acc_be;
`else
    logic        unused_be;
    assign unused_be = ^req_be_i;
`endif

    // Next-state, wait counter and handshake outputs
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        enter_resp  = 1'b0;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (LATENCY == 1) begin
                        state_next = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = 4'(LATENCY - 2);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_next = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // With LATENCY=1 the access edge is the accept edge, so the live request
    // is used while idle and the latched copy otherwise.
    always_comb begin
        acc_we    = (state == S_IDLE) ? req_we_i    : lat_we;
        acc_addr  = (state == S_IDLE) ? req_addr_i  : lat_addr;
        acc_wdata = (state == S_IDLE) ? req_wdata_i : lat_wdata;
        acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));
        acc_idx   = acc_addr[IDX_W+1:2];
`ifdef DMEM_BYTE_EN_EN
        acc_be    = (state == S_IDLE) ? req_be_i : lat_be;
        for (int unsigned k = 0; k < 4; k++) begin
            wr_mask[8*k +: 8] = {8{acc_be[k]}};
        end
`else
        wr_mask   = '1;
`endif
        wr_word   = (mem[acc_idx] & ~wr_mask) | (acc_wdata & wr_mask);
    end

    // State register, wait counter and request latch
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
`ifdef DMEM_BYTE_EN_EN
            lat_be    <= '0;
`endif
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == S_IDLE && req_valid_i) begin
                lat_we    <= req_we_i;
                lat_addr  <= req_addr_i;
                lat_wdata <= req_wdata_i;
`ifdef DMEM_BYTE_EN_EN
                lat_be    <= req_be_i;
`endif
            end
        end
    end

    // Array: cleared on reset, store commits on the edge entering RESP
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (enter_resp && acc_we && !acc_err) begin
            mem[acc_idx] <= wr_word;
        end
    end

    // Response data/error: sampled entering RESP, held until consumed
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else if (enter_resp) begin
            rsp_rdata_o <= (acc_we || acc_err) ? 32'h0 : mem[acc_idx];
            rsp_err_o   <= acc_err;
        end else if (state == S_RESP && rsp_ready_i) begin
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH_WORDS=128, LATENCY=2).
// Expected byte-enable results follow DMEM_BYTE_EN_EN.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned LAT   = 2;

`ifdef DMEM_BYTE_EN_EN
    localparam logic [31:0] EXP_BE_MIX  = 32'h11BB33DD;
    localparam logic [31:0] EXP_BE_NONE = 32'h00000000;
`else
    localparam logic [31:0] EXP_BE_MIX  = 32'hAABBCCDD;
    localparam logic [31:0] EXP_BE_NONE = 32'hFFFFFFFF;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_ready"}, 32'(req_ready_o), 32'd1);
        check({nm, "_valid"}, 32'(rsp_valid_o), 32'd0);
        check({nm, "_rdata"}, rsp_rdata_o, 32'h0);
        check({nm, "_err"},   32'(rsp_err_o),   32'd0);
        check({nm, "_busy"},  32'(busy_o),      32'd0);
    endtask

    // Called and returns at a negedge; issues one request and consumes its response.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err,
                       output int lat);
        int guard = 0;
        while (req_ready_o !== 1'b1 && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 20) check("txn_ready_timeout", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        rsp_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk_i);
            lat++;
            check("ready_low_in_flight", 32'(req_ready_o), 32'd0);
            check("busy_in_flight",      32'(busy_o),      32'd1);
            if (rsp_valid_o) break;
        end
        rdata = rsp_rdata_o;
        err   = rsp_err_o;
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_handshake", 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        int          accepts [$];
        int          nrsp;
        int          guard;

        //            we    addr          wdata         be       exp_rdata     err
        vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0020, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0020, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0022, 32'h0,        4'hF, 32'h0,        1'b1};
        vecs[4]  = '{1'b0, 32'h0000_0200, 32'h0,        4'hF, 32'h0,        1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0022, 32'h12345678, 4'hF, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0020, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_01FC, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 32'h0000_01FC, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0200, 32'h00000001, 4'hF, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,        4'hF, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h0000_01FC, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
        vecs[12] = '{1'b0, 32'h8000_0000, 32'h0,        4'hF, 32'h0,        1'b1};
        vecs[13] = '{1'b1, 32'h0000_0030, 32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[14] = '{1'b1, 32'h0000_0030, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 32'h0000_0030, 32'h0,        4'hF, EXP_BE_MIX,   1'b0};
        vecs[16] = '{1'b1, 32'h0000_0034, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vecs[17] = '{1'b0, 32'h0000_0034, 32'h0,        4'hF, EXP_BE_NONE,  1'b0};

        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_be_i    = '0;
        rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset_init");
        rst_i = 1'b1;
        @(negedge clk_i);
        check_reset_outputs("post_reset");

        for (int i = 0; i < NVEC; i++) begin
            txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lt);
            check($sformatf("vec%0d_rdata", i),   rd,         vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i),     32'(er),    32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lt),    32'(LAT));
        end

        // Back-to-back loads with request and response always ready.
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h20;
        rsp_ready_i = 1'b1;
        nrsp        = 0;
        for (int c = 0; c <= 8; c++) begin
            if (req_ready_o) accepts.push_back(c);
            if (rsp_valid_o) begin
                nrsp++;
                check($sformatf("b2b_rdata_c%0d", c), rsp_rdata_o, 32'hDEADBEEF);
            end
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        check("b2b_accept_count", 32'(accepts.size()), 32'd3);
        check("b2b_response_count", 32'(nrsp), 32'd3);
        if (accepts.size() >= 2)
            check("b2b_spacing", 32'(accepts[1] - accepts[0]), 32'(LAT + 1));
        check("b2b_idle_after", 32'(req_ready_o), 32'd1);

        // Response stall: held stable, no new accept while a request waits.
        req_valid_i = 1'b1;
        req_addr_i  = 32'h20;
        @(posedge clk_i);
        #1;
        req_addr_i  = 32'h1FC;
        guard = 0;
        @(negedge clk_i);
        while (!rsp_valid_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        check("stall_valid_reached", 32'(rsp_valid_o), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check($sformatf("stall_valid_c%0d", c), 32'(rsp_valid_o), 32'd1);
            check($sformatf("stall_rdata_c%0d", c), rsp_rdata_o,      32'hDEADBEEF);
            check($sformatf("stall_ready_c%0d", c), 32'(req_ready_o), 32'd0);
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        check("stall_released_ready", 32'(req_ready_o), 32'd1);
        check("stall_released_busy",  32'(busy_o),      32'd0);
        check("stall_released_valid", 32'(rsp_valid_o), 32'd0);

        // Reset during WAIT drops the store and clears the array.
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h40;
        req_wdata_i = 32'h55;
        req_be_i    = 4'hF;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        @(negedge clk_i);
        check("pre_reset_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("mid_reset_hold");
        rst_i = 1'b1;
        @(negedge clk_i);
        txn(1'b0, 32'h40, 32'h0, 4'hF, rd, er, lt);
        check("reset_store_dropped", rd, 32'h0);
        check("reset_store_err", 32'(er), 32'd0);
        txn(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lt);
        check("reset_array_cleared", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
